// File: rtl/sdfifo_pack32.sv
// sdfifo_pack32: drains the SD data-path byte FIFO one block at a time and
// packs four bytes per 32-bit word onto a valid/ready stream. The final word
// of the block is marked with o_last, and o_done pulses once that word has
// been accepted.
module sdfifo_pack32 #(
  parameter int LGBLK             = 9,
  parameter bit OPT_LITTLE_ENDIAN = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_fifo_empty,
  input  logic [7:0]  i_fifo_data,
  output logic        o_fifo_rd,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic        o_last,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_t;

  localparam int             BLK_BYTES = 1 << LGBLK;
  localparam logic [LGBLK:0] CNT_INIT  = (LGBLK+1)'(BLK_BYTES);

  state_t         r_state, w_nxt;
  logic [LGBLK:0] r_cnt;
  logic [1:0]     r_idx;
  logic [23:0]    r_acc;
  logic           w_accept, w_word_ld, w_final;
  logic [31:0]    w_word;

  // The 4th byte of a word is only read once the output register is free
  // (empty, or being accepted this cycle); bytes 0-2 only touch the accumulator.
  assign o_fifo_rd = (r_state == S_FILL) && !i_reset && !i_abort && !i_fifo_empty
                   && (r_idx != 2'd3 || !o_valid || i_ready);
  assign w_accept  = o_valid && i_ready;
  assign w_word_ld = o_fifo_rd && (r_idx == 2'd3);
  // The block is a multiple of four bytes, so its final byte always completes a word.
  assign w_final   = (r_cnt == (LGBLK+1)'(1));
  assign w_word    = OPT_LITTLE_ENDIAN ? {i_fifo_data, r_acc[7:0], r_acc[15:8], r_acc[23:16]}
                                       : {r_acc, i_fifo_data};
  assign o_busy    = (r_state != S_IDLE);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_nxt;
  end

  // Next-state: abort overrides every transition, including a start in IDLE
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_nxt = S_FILL;
      S_FILL:  if (w_word_ld && w_final) w_nxt = S_DRAIN;
      S_DRAIN: if (w_accept) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    if (i_abort) w_nxt = S_IDLE;
  end

  // Byte accumulation, word output register and completion strobe
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_done  <= 1'b0;
    end else if (i_abort) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (r_state == S_IDLE && i_start) begin
        r_cnt <= CNT_INIT;
        r_idx <= '0;
      end
      if (o_fifo_rd) begin
        r_acc <= {r_acc[15:0], i_fifo_data};
        r_idx <= r_idx + 2'd1;
        r_cnt <= r_cnt - (LGBLK+1)'(1);
      end
      if (w_word_ld) begin
        o_data  <= w_word;
        o_valid <= 1'b1;
        o_last  <= w_final;
      end else if (w_accept) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
        if (r_state == S_DRAIN) o_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdfifo_pack32.sv
// Directed bench for sdfifo_pack32 (LGBLK=4). A big-endian and a
// little-endian instance share all inputs; the FIFO model pops on the
// big-endian read strobe. Expected words are queued when bytes are loaded
// and compared on each handshake.
`timescale 1ns/100ps
module tb_sdfifo_pack32;

  typedef struct {
    logic [31:0] be;
    logic [31:0] le;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_abort, i_fifo_empty, i_ready;
  logic [7:0]  i_fifo_data;
  logic        rd_be, vld_be, last_be, busy_be, done_be;
  logic [31:0] data_be;
  logic        rd_le, vld_le, last_le, busy_le, done_le;
  logic [31:0] data_le;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int rd_cnt = 0;
  bit gap_en = 0;
  bit gap    = 0;
  bit rd_s   = 0;
  logic [7:0] fifo_q[$];
  exp_t       exp_q[$];

  bit          done_exp = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  logic        prev_last;

  always #5 clk = ~clk;

  sdfifo_pack32 #(.LGBLK(4), .OPT_LITTLE_ENDIAN(1'b0)) u_be (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data), .o_fifo_rd(rd_be),
    .o_valid(vld_be), .i_ready(i_ready), .o_data(data_be), .o_last(last_be),
    .o_busy(busy_be), .o_done(done_be));

  sdfifo_pack32 #(.LGBLK(4), .OPT_LITTLE_ENDIAN(1'b1)) u_le (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data), .o_fifo_rd(rd_le),
    .o_valid(vld_le), .i_ready(i_ready), .o_data(data_le), .o_last(last_le),
    .o_busy(busy_le), .o_done(done_le));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic fifo_out();
    i_fifo_empty = gap || (fifo_q.size() == 0);
    i_fifo_data  = i_fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  // FIFO model: pops just after the edge on which the DUT consumed the head byte
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rd_s && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      rd_cnt++;
    end
    gap = gap_en ? ~gap : 1'b0;
    fifo_out();
  end

  // Monitor: read-while-empty, done timing, stall stability, scoreboard
  always @(negedge clk) begin
    exp_t e;
    rd_s = rd_be;
    if (i_fifo_empty) chk("rd_while_empty", {31'd0, rd_be}, 32'd0);
    chk("done", {31'd0, done_be}, {31'd0, done_exp});
    if (done_be) chk("busy_at_done", {31'd0, busy_be}, 32'd0);
    chk("le_vld_match", {31'd0, vld_le}, {31'd0, vld_be});
    if (prev_stall) begin
      chk("stall_data", data_be, prev_data);
      chk("stall_last", {31'd0, last_be}, {31'd0, prev_last});
    end
    done_exp = 0;
    if (vld_be && i_ready && !i_abort && !i_reset) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", data_be, 32'hxxxxxxxx);
      end else begin
        e = exp_q.pop_front();
        chk("word_be", data_be, e.be);
        chk("word_le", data_le, e.le);
        chk("word_last", {31'd0, last_be}, {31'd0, e.last});
        done_exp = e.last;
      end
    end
    prev_stall = vld_be && !i_ready && !i_abort && !i_reset;
    prev_data  = data_be;
    prev_last  = last_be;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Loads one block (16 bytes from base) plus 4 trailing bytes that must never be read
  task automatic preload(input logic [7:0] base);
    exp_t e;
    fifo_q.delete();
    exp_q.delete();
    rd_cnt = 0;
    for (int w = 0; w < 4; w++) begin
      logic [7:0] b[4];
      for (int k = 0; k < 4; k++) begin
        b[k] = base + 8'(4*w + k);
        fifo_q.push_back(b[k]);
      end
      e.be   = {b[0], b[1], b[2], b[3]};
      e.le   = {b[3], b[2], b[1], b[0]};
      e.last = (w == 3);
      exp_q.push_back(e);
    end
    for (int k = 0; k < 4; k++) fifo_q.push_back(8'hEE);
    fifo_out();
  endtask

  task automatic wait_done(input int c0, input int bound, output int cycles);
    int n = 0;
    while (!done_be && n < bound) begin
      step();
      n++;
    end
    if (!done_be) chk("done_timeout", 32'd0, 32'd1);
    cycles = cyc - c0;
  endtask

  task automatic pulse_start(output int c0);
    i_start = 1;
    c0 = cyc;
    step();
    i_start = 0;
  endtask

  initial begin
    int c0, cyc_n;
    i_reset = 1; i_start = 0; i_abort = 0; i_ready = 1;
    fifo_out();
    step(2);
    preload(8'h00);
    step();
    chk("rst_rd", {31'd0, rd_be}, 32'd0);
    chk("rst_valid", {31'd0, vld_be}, 32'd0);
    chk("rst_data", data_be, 32'd0);
    chk("rst_last", {31'd0, last_be}, 32'd0);
    chk("rst_busy", {31'd0, busy_be}, 32'd0);
    chk("rst_done", {31'd0, done_be}, 32'd0);
    i_reset = 0;
    step();
    chk("idle_no_rd", {31'd0, rd_be}, 32'd0);

    // Basic block
    pulse_start(c0);
    chk("busy_after_start", {31'd0, busy_be}, 32'd1);
    step(3);
    chk("valid_c4", {31'd0, vld_be}, 32'd0);
    step();
    chk("valid_c5", {31'd0, vld_be}, 32'd1);
    wait_done(c0, 100, cyc_n);
    chk("basic_done_cycle", 32'(cyc_n), 32'd18);
    step(3);
    chk("basic_reads", 32'(rd_cnt), 32'd16);
    chk("basic_exp_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure after the first word
    preload(8'h00);
    pulse_start(c0);
    step(4);
    i_ready = 0;
    step(10);
    chk("bp_reads", 32'(rd_cnt), 32'd7);
    chk("bp_valid", {31'd0, vld_be}, 32'd1);
    chk("bp_data", data_be, 32'h00010203);
    chk("bp_rd_low", {31'd0, rd_be}, 32'd0);
    i_ready = 1;
    wait_done(c0, 100, cyc_n);
    step(3);
    chk("bp_reads_total", 32'(rd_cnt), 32'd16);
    chk("bp_exp_empty", 32'(exp_q.size()), 32'd0);

    // FIFO gaps
    preload(8'h00);
    gap_en = 1;
    pulse_start(c0);
    wait_done(c0, 200, cyc_n);
    step(3);
    gap_en = 0;
    chk("gap_reads", 32'(rd_cnt), 32'd16);
    chk("gap_exp_empty", 32'(exp_q.size()), 32'd0);

    // Abort after 6 bytes, then a fresh block
    preload(8'h00);
    pulse_start(c0);
    step(6);
    chk("abort_pre_reads", 32'(rd_cnt), 32'd6);
    i_abort = 1;
    exp_q.delete();
    step(0);
    #0;
    chk("abort_rd_forced", {31'd0, rd_be}, 32'd0);
    step();
    i_abort = 0;
    chk("abort_valid", {31'd0, vld_be}, 32'd0);
    chk("abort_busy", {31'd0, busy_be}, 32'd0);
    chk("abort_last", {31'd0, last_be}, 32'd0);
    step(5);
    chk("abort_reads", 32'(rd_cnt), 32'd6);
    preload(8'h40);
    pulse_start(c0);
    wait_done(c0, 100, cyc_n);
    chk("post_abort_cycle", 32'(cyc_n), 32'd18);
    step(3);
    chk("post_abort_reads", 32'(rd_cnt), 32'd16);
    chk("post_abort_exp_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-FILL
    preload(8'h80);
    pulse_start(c0);
    step(6);
    i_reset = 1;
    exp_q.delete();
    #0;
    chk("rst_mid_rd", {31'd0, rd_be}, 32'd0);
    step();
    i_reset = 0;
    chk("rst_mid_valid", {31'd0, vld_be}, 32'd0);
    chk("rst_mid_data", data_be, 32'd0);
    chk("rst_mid_last", {31'd0, last_be}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy_be}, 32'd0);
    chk("rst_mid_done", {31'd0, done_be}, 32'd0);

    // Start while busy is ignored
    step();
    preload(8'hA0);
    pulse_start(c0);
    step(2);
    i_start = 1;
    step();
    i_start = 0;
    step(2);
    i_start = 1;
    step();
    i_start = 0;
    wait_done(c0, 100, cyc_n);
    chk("ign_start_cycle", 32'(cyc_n), 32'd18);
    step(3);
    chk("ign_start_reads", 32'(rd_cnt), 32'd16);
    chk("ign_start_idle", {31'd0, busy_be}, 32'd0);
    chk("ign_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
